// File: rtl/hazard_ctrl.sv
//============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard unit for a 5-stage MIPS-style core.
//               Detects load-use, branch-in-D and mult/div hazards,
//               produces stall/flush controls and operand forwarding
//               selects. Also tracks the multi-cycle mult/div unit and
//               keeps a saturating count of stalled cycles.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module hazard_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  // source registers of D and E
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  input  logic [4:0]  rsE,
  input  logic [4:0]  rtE,
  // destination registers of E, M, W
  input  logic [4:0]  a_E,
  input  logic [4:0]  a_M,
  input  logic [4:0]  a_W,
  input  logic        regwrite_E,
  input  logic        regwrite_M,
  input  logic        regwrite_W,
  input  logic        memtoreg_E,
  input  logic        memtoreg_M,
  // D-stage operand usage
  input  logic        use_rs_D,
  input  logic        use_rt_D,
  input  logic        branch_D,
  // mult/div unit
  input  logic        md_start_E,
  input  logic        md_is_div_E,
  input  logic        md_use_D,
  // stall / flush
  output logic        stall_F,
  output logic        stall_D,
  output logic        clr_E,
  // forwarding selects
  output logic        fwd_rsD,
  output logic        fwd_rtD,
  output logic [1:0]  fwd_rsE,
  output logic [1:0]  fwd_rtE,
  // status
  output logic        md_busy,
  output logic [15:0] stall_cnt
);

  // Forwarding select encodings for the E-stage operand muxes.
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Busy lengths of the mult/div unit, counted from the issue edge.
  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

  // Register state
  logic [3:0]  md_cnt_q,    md_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Register 0 is hard-wired to zero and can never be a real dependency.
  logic rsD_nz, rtD_nz, rsE_nz, rtE_nz;
  assign rsD_nz = (rsD != 5'd0);
  assign rtD_nz = (rtD != 5'd0);
  assign rsE_nz = (rsE != 5'd0);
  assign rtE_nz = (rtE != 5'd0);

  // Raw register-number matches against the downstream destinations.
  logic rsD_eq_E, rtD_eq_E, rsD_eq_M, rtD_eq_M;
  logic rsE_eq_M, rtE_eq_M, rsE_eq_W, rtE_eq_W;
  assign rsD_eq_E = rsD_nz && (rsD == a_E);
  assign rtD_eq_E = rtD_nz && (rtD == a_E);
  assign rsD_eq_M = rsD_nz && (rsD == a_M);
  assign rtD_eq_M = rtD_nz && (rtD == a_M);
  assign rsE_eq_M = rsE_nz && (rsE == a_M);
  assign rtE_eq_M = rtE_nz && (rtE == a_M);
  assign rsE_eq_W = rsE_nz && (rsE == a_W);
  assign rtE_eq_W = rtE_nz && (rtE == a_W);

  logic lu_stall;
  logic br_stall;
  logic md_stall;
  logic stall;

  // Stall conditions: load-use, branch operand not yet available, mult/div busy.
  always_comb begin
    lu_stall = memtoreg_E && ((use_rs_D && rsD_eq_E) || (use_rt_D && rtD_eq_E));

    // A branch in D compares operands immediately, so it must wait for any
    // ALU result still in E and any load result still in M.
    br_stall = branch_D &&
               ((regwrite_E && (rsD_eq_E || rtD_eq_E)) ||
                (memtoreg_M && (rsD_eq_M || rtD_eq_M)));

    // A newly issued op counts as busy in its issue cycle even though the
    // counter only loads on the following edge.
    md_stall = md_use_D && (md_busy || md_start_E);

    stall    = lu_stall || br_stall || md_stall;
  end

  assign stall_F = stall;
  assign stall_D = stall;
  assign clr_E   = stall;

  // E-stage forwarding: the younger M result wins over W.
  always_comb begin
    fwd_rsE = FWD_RF;
    fwd_rtE = FWD_RF;
    if (regwrite_M && rsE_eq_M)      fwd_rsE = FWD_M;
    else if (regwrite_W && rsE_eq_W) fwd_rsE = FWD_W;
    if (regwrite_M && rtE_eq_M)      fwd_rtE = FWD_M;
    else if (regwrite_W && rtE_eq_W) fwd_rtE = FWD_W;
  end

  // D-stage forwarding from M; a load in M has no data yet, so it is excluded
  // (the branch stall covers that case).
  always_comb begin
    fwd_rsD = regwrite_M && !memtoreg_M && rsD_eq_M;
    fwd_rtD = regwrite_M && !memtoreg_M && rtD_eq_M;
  end

  // Mult/div countdown: load on issue when idle, ignore issue while counting.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_cnt_q != 4'd0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end else if (md_start_E) begin
      md_cnt_d = md_is_div_E ? DIV_CYCLES : MULT_CYCLES;
    end
  end

  // Stalled-cycle counter, saturating instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != STALL_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // State registers; reset also aborts an in-flight mult/div.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      md_cnt_q    <= 4'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign md_busy   = (md_cnt_q != 4'd0);
  assign stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire
